// File: rtl/hosted_pkg.sv
// rtl/hosted_pkg.sv - shared types and constants for the hosted read arbiter
// Purpose : FSM state and owner enums, the latched AR request struct and AXI
//           response codes used by hosted_rd_arbiter and hosted_rr_arb2.
// Ports   : none (package).
// Note    : the AR struct carries id/addr at their widest supported size
//           (RDARB_ID_MAX / RDARB_ADDR_MAX); users truncate to ID_W / ADDR_W.
package hosted_pkg;

  localparam int RDARB_ID_MAX   = 32;
  localparam int RDARB_ADDR_MAX = 64;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} rdarb_state_e;

  typedef enum logic {OWN_IMEM, OWN_DMEM} owner_e;

  typedef struct packed {
    logic [RDARB_ID_MAX-1:0]   id;
    logic [7:0]                len;
    logic [2:0]                size;
    logic [1:0]                burst;
    logic [RDARB_ADDR_MAX-1:0] addr;
  } ar_req_t;

endpackage

// File: rtl/hosted_rr_arb2.sv
// rtl/hosted_rr_arb2.sv - two-request arbiter for the hosted read arbiter
// Purpose : one-hot grant over {dmem, imem}; round-robin on ties by default,
//           fixed dmem priority when HOSTED_RDARB_DPRIO_EN is defined.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           req[1:0]      - requests, bit0 = imem, bit1 = dmem
//           advance       - grant is consumed this cycle (updates last_owner)
//           gnt[1:0]      - one-hot grant, same bit order as req
// Macro   : HOSTED_RDARB_DPRIO_EN
module hosted_rr_arb2
  import hosted_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

`ifdef HOSTED_RDARB_DPRIO_EN
  logic unused_arb;
  assign unused_arb = ^{clk, rst, advance};

  always_comb begin
    gnt = 2'b00;
    if (req[1])      gnt = 2'b10;
    else if (req[0]) gnt = 2'b01;
  end
`else
  owner_e last_owner;

  // On a tie the side that did not win last time gets the grant.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (last_owner == OWN_IMEM) ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= OWN_IMEM;
    end else if (advance && (gnt != 2'b00)) begin
      last_owner <= gnt[1] ? OWN_DMEM : OWN_IMEM;
    end
  end
`endif

endmodule

// File: rtl/hosted_rd_arbiter.sv
// rtl/hosted_rd_arbiter.sv - shares one AXI AR/R port between imem and dmem reads
// Purpose : grants one upstream AR, replays it downstream, then steers every R
//           beat to the owner until rlast. One transaction outstanding at most.
// Ports   : clk, rst                 - clock, synchronous active-high reset
//           i_ar* / i_r*             - imem read requester (bursts)
//           d_ar* / d_r*             - dmem read requester (single beats)
//           m_ar* / m_r*             - downstream fabric read port
//           err_sticky               - burst-length violation seen since reset
// Macro   : HOSTED_RDARB_DPRIO_EN (fixed dmem priority, see hosted_rr_arb2)
// Limits  : ID_W <= 32, ADDR_W <= 64.
module hosted_rd_arbiter
  import hosted_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_arvalid,
  output logic              i_arready,
  input  logic [ID_W-1:0]   i_arid,
  input  logic [7:0]        i_arlen,
  input  logic [2:0]        i_arsize,
  input  logic [1:0]        i_arburst,
  input  logic [ADDR_W-1:0] i_araddr,
  output logic              i_rvalid,
  input  logic              i_rready,
  output logic [ID_W-1:0]   i_rid,
  output logic [DATA_W-1:0] i_rdata,
  output logic [1:0]        i_rresp,
  output logic              i_rlast,
  input  logic              d_arvalid,
  output logic              d_arready,
  input  logic [ID_W-1:0]   d_arid,
  input  logic [7:0]        d_arlen,
  input  logic [2:0]        d_arsize,
  input  logic [1:0]        d_arburst,
  input  logic [ADDR_W-1:0] d_araddr,
  output logic              d_rvalid,
  input  logic              d_rready,
  output logic [ID_W-1:0]   d_rid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [1:0]        d_rresp,
  output logic              d_rlast,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ID_W-1:0]   m_arid,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic [ADDR_W-1:0] m_araddr,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [ID_W-1:0]   m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  output logic              err_sticky
);

  rdarb_state_e state, state_nxt;
  owner_e       owner;
  ar_req_t      lat, win_req;
  logic [7:0]   beats_left;
  logic [1:0]   req, gnt;
  logic         in_idle, in_data, r_hs;

  assign in_idle = (state == IDLE);
  assign in_data = (state == DATA);
  // Requests are only visible to the arbiter in IDLE, so gnt doubles as arready.
  assign req     = {d_arvalid, i_arvalid} & {2{in_idle}};

  hosted_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (in_idle),
    .gnt     (gnt)
  );

  assign i_arready = gnt[0];
  assign d_arready = gnt[1];

  always_comb begin
    win_req.id    = RDARB_ID_MAX'(i_arid);
    win_req.len   = i_arlen;
    win_req.size  = i_arsize;
    win_req.burst = i_arburst;
    win_req.addr  = RDARB_ADDR_MAX'(i_araddr);
    if (gnt[1]) begin
      win_req.id    = RDARB_ID_MAX'(d_arid);
      win_req.len   = d_arlen;
      win_req.size  = d_arsize;
      win_req.burst = d_arburst;
      win_req.addr  = RDARB_ADDR_MAX'(d_araddr);
    end
  end

  assign m_arvalid = (state == ADDR);
  assign m_arid    = lat.id[ID_W-1:0];
  assign m_arlen   = lat.len;
  assign m_arsize  = lat.size;
  assign m_arburst = lat.burst;
  assign m_araddr  = lat.addr[ADDR_W-1:0];

  // R payload is broadcast; only the owner's valid is raised.
  assign i_rvalid = in_data && (owner == OWN_IMEM) && m_rvalid;
  assign d_rvalid = in_data && (owner == OWN_DMEM) && m_rvalid;
  assign m_rready = in_data && ((owner == OWN_DMEM) ? d_rready : i_rready);
  assign r_hs     = in_data && m_rvalid && m_rready;

  assign i_rid   = m_rid;
  assign i_rdata = m_rdata;
  assign i_rresp = m_rresp;
  assign i_rlast = m_rlast;
  assign d_rid   = m_rid;
  assign d_rdata = m_rdata;
  assign d_rresp = m_rresp;
  assign d_rlast = m_rlast;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt != 2'b00) state_nxt = ADDR;
      ADDR:    if (m_arready) state_nxt = DATA;
      DATA:    if (r_hs && m_rlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_IMEM;
      lat        <= '0;
      beats_left <= '0;
      err_sticky <= 1'b0;
    end else begin
      state <= state_nxt;
      if (gnt != 2'b00) begin
        owner      <= gnt[1] ? OWN_DMEM : OWN_IMEM;
        lat        <= win_req;
        beats_left <= win_req.len;
      end
      if (r_hs) begin
        if (beats_left != 8'd0) beats_left <= beats_left - 8'd1;
        // Early rlast or a beat past the expected last one; the burst still
        // ends only on rlast so the fabric and arbiter stay in step.
        if ((m_rlast && (beats_left != 8'd0)) || (!m_rlast && (beats_left == 8'd0)))
          err_sticky <= 1'b1;
      end
    end
  end

endmodule
